axi4_slave_mem: RTL and testbench

- Synthesizable AXI4 burst slave backed by a word-addressed register-file memory.
- Sits directly downstream of axi4_master and consumes its AW/W/B and AR/R channels.
- Accepts INCR bursts of 1 to 256 beats and returns write responses and read data.
- Write and read paths are independent FSMs sharing one memory array.

---
 rtl/axi4_slave_mem.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
// AXI4 INCR burst slave over a word-addressed register-file memory.
// Optional BRESP/RRESP error signalling with bounds checking: define AXI_SLV_ERR_RESP_EN.
module axi4_slave_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
`ifdef AXI_SLV_ERR_RESP_EN
  output logic [1:0]        BRESP,
  output logic [1:0]        RRESP,
`endif
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  wstate_t           wstate_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        awlen_q, wbeat_q;
  logic              wr_hs, wr_last, mem_we;

  rstate_t           rstate_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [31:0]       rdata_q, rd_word;
  logic [ADDR_W-1:0] raddr_q, rd_addr;
  logic [7:0]        arlen_q, rbeat_q;

`ifdef AXI_SLV_ERR_RESP_EN
  logic       werr_q, werr_nxt, rd_err;
  logic [1:0] bresp_q, rresp_q;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> 2) >= ADDR_W'(DEPTH);
  endfunction
`endif

  always_comb begin
    wr_hs   = (wstate_q == W_DATA) && WVALID && wready_q;
    wr_last = (wbeat_q == awlen_q);
    mem_we  = wr_hs;
`ifdef AXI_SLV_ERR_RESP_EN
    werr_nxt = werr_q | out_of_range(waddr_q) | (WLAST != wr_last);
    if (out_of_range(waddr_q)) mem_we = 1'b0;
`endif
  end

  // Address mux lets the first beat load on the AR handshake edge itself.
  always_comb begin
    rd_addr = (rstate_q == R_IDLE) ? ARADDR : raddr_q;
    rd_word = mem[rd_addr[IDX_W+1:2]];
`ifdef AXI_SLV_ERR_RESP_EN
    rd_err = out_of_range(rd_addr);
    if (rd_err) rd_word = '0;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[waddr_q[IDX_W+1:2]] <= WDATA;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      wbeat_q   <= '0;
`ifdef AXI_SLV_ERR_RESP_EN
      werr_q    <= 1'b0;
      bresp_q   <= 2'b00;
`endif
    end else begin
      case (wstate_q)
        W_IDLE: if (AWVALID && awready_q) begin
          waddr_q   <= AWADDR;
          awlen_q   <= AWLEN;
          wbeat_q   <= '0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
`ifdef AXI_SLV_ERR_RESP_EN
          werr_q    <= 1'b0;
`endif
        end
        W_DATA: if (wr_hs) begin
          waddr_q <= waddr_q + ADDR_W'(4);
          wbeat_q <= wbeat_q + 8'd1;
`ifdef AXI_SLV_ERR_RESP_EN
          werr_q  <= werr_nxt;
`endif
          if (wr_last) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            wstate_q <= W_RESP;
`ifdef AXI_SLV_ERR_RESP_EN
            bresp_q  <= werr_nxt ? 2'b10 : 2'b00;
`endif
          end
        end
        W_RESP: if (BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      rbeat_q   <= '0;
`ifdef AXI_SLV_ERR_RESP_EN
      rresp_q   <= 2'b00;
`endif
    end else begin
      case (rstate_q)
        R_IDLE: if (ARVALID && arready_q) begin
          raddr_q   <= ARADDR + ADDR_W'(4);
          arlen_q   <= ARLEN;
          rbeat_q   <= '0;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rlast_q   <= (ARLEN == 8'd0);
          rdata_q   <= rd_word;
          rstate_q  <= R_DATA;
`ifdef AXI_SLV_ERR_RESP_EN
          rresp_q   <= rd_err ? 2'b10 : 2'b00;
`endif
        end
        R_DATA: if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end else begin
            rdata_q <= rd_word;
            raddr_q <= raddr_q + ADDR_W'(4);
            rbeat_q <= rbeat_q + 8'd1;
            rlast_q <= ((rbeat_q + 8'd1) == arlen_q);
`ifdef AXI_SLV_ERR_RESP_EN
            rresp_q <= rd_err ? 2'b10 : 2'b00;
`endif
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RDATA   = rdata_q;
`ifdef AXI_SLV_ERR_RESP_EN
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
`endif

  // Low address bits and (in the wrapping build) upper bits and WLAST carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{WLAST, waddr_q, rd_addr};

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: expected read words are queued before each
// read burst and popped as R beats complete.
module tb_axi4_slave_mem;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [ADDR_W-1:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]        AWLEN = '0, ARLEN = '0;
  logic              AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
  logic              ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0]       WDATA = '0;
  logic              AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [31:0]       RDATA;
`ifdef AXI_SLV_ERR_RESP_EN
  logic [1:0]        BRESP, RRESP, last_bresp;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  axi4_slave_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
`ifdef AXI_SLV_ERR_RESP_EN
    .BRESP(BRESP), .RRESP(RRESP),
`endif
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_write(input logic [31:0] addr, input int len, input logic [31:0] d0,
                             output int stalls, output int bdelay, output bit ok);
    int guard;
    ok = 1'b1;
    stalls = 0;
    AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    guard = 0;
    while (!AWREADY && guard < 50) begin tick(); guard++; end
    if (!AWREADY) ok = 1'b0;
    tick();
    AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      WDATA = d0 + 32'(b); WLAST = (b == len); WVALID = 1'b1;
      guard = 0;
      while (!WREADY && guard < 50) begin tick(); guard++; stalls++; end
      if (!WREADY) ok = 1'b0;
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    bdelay = 0;
    while (!BVALID && bdelay < 50) begin tick(); bdelay++; end
    if (!BVALID) ok = 1'b0;
`ifdef AXI_SLV_ERR_RESP_EN
    last_bresp = BRESP;
`endif
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic read_and_score(input logic [31:0] addr, input int len, input bit stall_en);
    int guard, beats, cyc;
    logic rr, stalled, hl, ev;
    logic [31:0] hd, exp;
    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
    guard = 0;
    while (!ARREADY && guard < 50) begin tick(); guard++; end
    tick();
    ARVALID = 1'b0;
    vectors++;
    if (RVALID !== 1'b1) begin
      miscompares++; $display("FAIL ar_to_rvalid: RVALID=%b expected 1", RVALID);
    end
    beats = 0; cyc = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
    while (beats <= len && cyc < 4000) begin
      rr = stall_en ? (cyc % 3 == 0) : 1'b1;
      RREADY = rr;
      if (RVALID && rr) begin
        exp = exp_q.pop_front();
        ev  = (beats == len);
        vectors++;
        if (RDATA !== exp) begin
          miscompares++; $display("FAIL rdata beat %0d: got %h expected %h", beats, RDATA, exp);
        end
        vectors++;
        if (RLAST !== ev) begin
          miscompares++; $display("FAIL rlast beat %0d: got %b expected %b", beats, RLAST, ev);
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = RVALID; hd = RDATA; hl = RLAST;
      end
      tick();
      cyc++;
      if (stalled) begin
        vectors++;
        if (RDATA !== hd || RLAST !== hl) begin
          miscompares++;
          $display("FAIL stall_hold: got %h/%b expected %h/%b", RDATA, RLAST, hd, hl);
        end
      end
    end
    RREADY = 1'b0;
    vectors++;
    if (beats != len + 1) begin
      miscompares++; $display("FAIL read_beats: got %0d expected %0d", beats, len + 1);
    end
    if (!stall_en) begin
      vectors++;
      if (cyc != len + 1) begin
        miscompares++; $display("FAIL read_throughput: %0d cycles expected %0d", cyc, len + 1);
      end
    end
    vectors++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      miscompares++; $display("FAIL read_done: RVALID=%b ARREADY=%b expected 0/1", RVALID, ARREADY);
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    ARESETn = 1'b0;
    tick(); tick();
    obs = {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST};
    vectors++;
    if (obs !== 6'b110000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 110000", obs);
    end
    vectors++;
    if (RDATA !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h expected 0", RDATA);
    end
`ifdef AXI_SLV_ERR_RESP_EN
    vectors++;
    if ({BRESP, RRESP} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_resp: got %b expected 0000", {BRESP, RRESP});
    end
`endif
    ARESETn = 1'b1;
    tick();
    vectors++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      miscompares++; $display("FAIL reset_release: got %b expected 11", {AWREADY, ARREADY});
    end
  endtask

  task automatic test_write_burst();
    int stalls, bdelay;
    bit ok;
    drive_write(32'h0, 3, 32'h100, stalls, bdelay, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL write_handshake: ok=%b expected 1", ok); end
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL wready_stalls: got %0d expected 0", stalls); end
    vectors++;
    if (bdelay != 0) begin miscompares++; $display("FAIL bvalid_latency: got %0d expected 0", bdelay); end
    vectors++;
    if ({AWREADY, BVALID, WREADY} !== 3'b100) begin
      miscompares++; $display("FAIL write_done: got %b expected 100", {AWREADY, BVALID, WREADY});
    end
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    read_and_score(32'h0, 3, 1'b0);
  endtask

  task automatic test_read_stall();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    read_and_score(32'h0, 3, 1'b1);
  endtask

  task automatic test_wrap();
    int stalls, bdelay;
    bit ok;
    drive_write(32'((DEPTH - 1) * 4), 1, 32'hA, stalls, bdelay, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wrap_write: ok=%b expected 1", ok); end
`ifdef AXI_SLV_ERR_RESP_EN
    vectors++;
    if (last_bresp !== 2'b10) begin
      miscompares++; $display("FAIL wrap_bresp: got %b expected 10", last_bresp);
    end
    exp_q.push_back(32'hA);
    read_and_score(32'((DEPTH - 1) * 4), 0, 1'b0);
    exp_q.push_back(32'h100);
    read_and_score(32'h0, 0, 1'b0);
`else
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    read_and_score(32'((DEPTH - 1) * 4), 1, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] obs;
    int stalls, bdelay;
    bit ok;
    AWADDR = 32'h40; AWLEN = 8'd3; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WDATA = 32'h300 + 32'(b); WVALID = 1'b1; WLAST = 1'b0;
      tick();
    end
    WVALID = 1'b0;
    ARESETn = 1'b0;
    #1;
    obs = {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST};
    vectors++;
    if (obs !== 6'b110000) begin
      miscompares++; $display("FAIL midreset_ctrl: got %b expected 110000", obs);
    end
    vectors++;
    if (RDATA !== 32'h0) begin
      miscompares++; $display("FAIL midreset_rdata: got %h expected 0", RDATA);
    end
    tick();
    ARESETn = 1'b1;
    tick();
    vectors++;
    if (AWREADY !== 1'b1) begin miscompares++; $display("FAIL midreset_awready: got %b expected 1", AWREADY); end
    drive_write(32'h40, 3, 32'h200, stalls, bdelay, ok);
    vectors++;
    if (ok !== 1'b1 || bdelay != 0) begin
      miscompares++; $display("FAIL midreset_rewrite: ok=%b bdelay=%0d expected 1/0", ok, bdelay);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i));
    read_and_score(32'h40, 3, 1'b0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    AWADDR = 32'h80; AWLEN = 8'd0; AWVALID = 1'b1;
    ARADDR = 32'h4;  ARLEN = 8'd0; ARVALID = 1'b1;
    exp_q.push_back(32'h101);
    vectors++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      miscompares++; $display("FAIL sim_ready: got %b expected 11", {AWREADY, ARREADY});
    end
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    vectors++;
    if ({AWREADY, ARREADY, WREADY, RVALID, RLAST} !== 5'b00111) begin
      miscompares++;
      $display("FAIL sim_accept: got %b expected 00111", {AWREADY, ARREADY, WREADY, RVALID, RLAST});
    end
    exp = exp_q.pop_front();
    vectors++;
    if (RDATA !== exp) begin miscompares++; $display("FAIL sim_rdata: got %h expected %h", RDATA, exp); end
    WDATA = 32'h55; WLAST = 1'b1; WVALID = 1'b1; RREADY = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
    vectors++;
    if ({BVALID, WREADY, RVALID, ARREADY} !== 4'b1001) begin
      miscompares++;
      $display("FAIL sim_resp: got %b expected 1001", {BVALID, WREADY, RVALID, ARREADY});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    vectors++;
    if ({AWREADY, BVALID} !== 2'b10) begin
      miscompares++; $display("FAIL sim_bdone: got %b expected 10", {AWREADY, BVALID});
    end
    exp_q.push_back(32'h55);
    read_and_score(32'h80, 0, 1'b0);
  endtask

  task automatic test_long_burst();
    int stalls, bdelay;
    bit ok;
    drive_write(32'h0, 255, 32'h1000, stalls, bdelay, ok);
    vectors++;
    if (ok !== 1'b1 || stalls != 0 || bdelay != 0) begin
      miscompares++;
      $display("FAIL long_write: ok=%b stalls=%0d bdelay=%0d expected 1/0/0", ok, stalls, bdelay);
    end
    for (int i = 0; i < 256; i++) exp_q.push_back(32'h1000 + 32'(i));
    read_and_score(32'h0, 255, 1'b0);
  endtask

  initial begin
    #1;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_wrap();
    test_reset_mid_burst();
    test_simultaneous();
    test_long_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
